// File: rtl/header_nonce_feeder_pkg.sv
// Shared types and sizes for the block-header nonce feeder.
// Imported by the top level; the nonce iterator is self-contained.
package sha_hdr_pkg;

  localparam int unsigned HDR_W      = 640;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned HDR_WORDS  = 20;
  localparam int unsigned LOAD_WORDS = 19;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } state_t;

  typedef logic [4:0] slot_idx_t;

  localparam slot_idx_t LAST_SLOT = 5'(LOAD_WORDS - 1);

endpackage

// File: rtl/hdr_nonce_iter.sv
// Nonce register for a header sweep: loads start/end, advances on step,
// and flags the final nonce of an inclusive (possibly wrapping) range.
module hdr_nonce_iter #(
  parameter int unsigned NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [NONCE_W-1:0] start,
  input  logic [NONCE_W-1:0] end_nonce,
  input  logic               step,
  output logic               is_last,
  output logic [NONCE_W-1:0] nonce
);

  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] end_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nonce_q <= '0;
      end_q   <= '0;
    end else if (load) begin
      nonce_q <= start;
      end_q   <= end_nonce;
    end else if (step) begin
      // Modular increment makes end < start sweep through the wrap point.
      nonce_q <= nonce_q + {{(NONCE_W-1){1'b0}}, 1'b1};
    end
  end

  assign is_last = (nonce_q == end_q);
  assign nonce   = nonce_q;

endmodule

// File: rtl/header_nonce_feeder.sv
// Loads 19 header words from a 32-bit stream, then emits one 640-bit header
// per downstream handshake while sweeping the nonce over an inclusive range.
module header_nonce_feeder
  import sha_hdr_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LOAD_WORDS = 19,
  parameter int unsigned NONCE_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               abort,
  output logic               hdr_valid,
  input  logic               hdr_ready,
  output logic [HDR_W-1:0]   header,
  output logic               busy,
  output logic               done,
  output logic               frame_err
);

  state_t             state_q, state_d;
  slot_idx_t          count_q;
  logic [WORD_W-1:0]  slots_q [LOAD_WORDS];
  logic               frame_err_q;

  logic               accept;
  logic               hs;
  logic               word_we;
  logic               count_inc;
  logic               count_clr;
  logic               err_set;
  logic               nonce_load;
  logic               nonce_step;
  logic               is_last;
  logic [NONCE_W-1:0] nonce;
  logic [HDR_W-1:0]   hdr_w;

  assign accept = in_valid && (state_q == LOAD);
  assign hs     = hdr_ready && (state_q == RUN);

  hdr_nonce_iter #(
    .NONCE_W (NONCE_W)
  ) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (nonce_load),
    .start     (nonce_start),
    .end_nonce (nonce_end),
    .step      (nonce_step),
    .is_last   (is_last),
    .nonce     (nonce)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    word_we    = 1'b0;
    count_inc  = 1'b0;
    count_clr  = 1'b0;
    err_set    = 1'b0;
    nonce_load = 1'b0;
    nonce_step = 1'b0;
    unique case (state_q)
      LOAD: begin
        // abort outranks a word arriving in the same cycle: that word is dropped.
        if (abort) begin
          count_clr = 1'b1;
        end else if (accept) begin
          if (count_q == LAST_SLOT) begin
            count_clr = 1'b1;
            if (in_last) begin
              word_we    = 1'b1;
              nonce_load = 1'b1;
              state_d    = RUN;
            end else begin
              err_set = 1'b1;
            end
          end else if (in_last) begin
            count_clr = 1'b1;
            err_set   = 1'b1;
          end else begin
            word_we   = 1'b1;
            count_inc = 1'b1;
          end
        end
      end
      RUN: begin
        // Handshake in an abort cycle is consumed downstream, but the sweep ends here.
        if (abort) begin
          state_d = LOAD;
        end else if (hs) begin
          if (is_last) state_d = DONE;
          else         nonce_step = 1'b1;
        end
      end
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      frame_err_q <= 1'b0;
      for (int unsigned i = 0; i < LOAD_WORDS; i++) slots_q[i] <= '0;
    end else begin
      frame_err_q <= err_set;
      if (count_clr)      count_q <= '0;
      else if (count_inc) count_q <= count_q + 5'd1;
      if (word_we) slots_q[count_q] <= in_data;
    end
  end

  always_comb begin
    hdr_w = '0;
    for (int unsigned i = 0; i < LOAD_WORDS; i++)
      hdr_w[HDR_W-1-i*WORD_W -: WORD_W] = slots_q[i];
    hdr_w[NONCE_W-1:0] = nonce;
  end

  // Outputs are forced low for the whole reset cycle, not just after it.
  assign in_ready  = rst_n && (state_q == LOAD);
  assign hdr_valid = rst_n && (state_q == RUN);
  assign busy      = rst_n && (state_q == RUN);
  assign done      = rst_n && (state_q == DONE);
  assign frame_err = rst_n && frame_err_q;
  assign header    = rst_n ? hdr_w : '0;

endmodule

// File: tb/tb_header_nonce_feeder.sv
// Scoreboarded bench for header_nonce_feeder: expected headers are queued as
// each frame is loaded and popped on every observed downstream handshake.
module tb_header_nonce_feeder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic         abort = 1'b0;
  logic         hdr_valid;
  logic         hdr_ready = 1'b0;
  logic [639:0] header;
  logic         busy;
  logic         done;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  logic [639:0] exp_q[$];
  logic [639:0] mon_exp;
  logic [639:0] prev_hdr = '0;
  logic         prev_stall = 1'b0;

  header_nonce_feeder #(
    .WORD_W     (32),
    .LOAD_WORDS (19),
    .NONCE_W    (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .abort       (abort),
    .hdr_valid   (hdr_valid),
    .hdr_ready   (hdr_ready),
    .header      (header),
    .busy        (busy),
    .done        (done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [639:0] build_hdr(input logic [31:0] base, input logic [31:0] n);
    logic [639:0] h;
    h = '0;
    for (int i = 0; i < 19; i++) h[639-32*i -: 32] = base + 32'(i);
    h[31:0] = n;
    return h;
  endfunction

  // Monitor: scoreboard pop on handshake, hold check after a stall.
  always @(negedge clk) begin
    if (prev_stall && rst_n) begin
      checks++;
      if (hdr_valid !== 1'b1 || header !== prev_hdr) begin
        errors++;
        $display("FAIL stall_hold: hdr_valid=%0b nonce=%h, required hdr_valid=1 nonce=%h unchanged header",
                 hdr_valid, header[31:0], prev_hdr[31:0]);
      end
    end
    if (rst_n && hdr_valid === 1'b1 && hdr_ready) begin
      hs_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hdr: nonce=%h word0=%h, required no handshake", header[31:0], header[639:608]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (header !== mon_exp) begin
          errors++;
          $display("FAIL hdr_data: nonce=%h word0=%h word18=%h, required nonce=%h word0=%h word18=%h",
                   header[31:0], header[639:608], header[63:32], mon_exp[31:0], mon_exp[639:608], mon_exp[63:32]);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
    prev_stall = rst_n && hdr_valid === 1'b1 && !hdr_ready && !abort;
    prev_hdr   = header;
  end

  task automatic load_frame(input logic [31:0] base, input int last_pos,
                            input logic [31:0] ns, input logic [31:0] ne);
    nonce_start = ns;
    nonce_end   = ne;
    for (int i = 0; i <= last_pos; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      in_last  = (i == last_pos);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic push_sweep(input logic [31:0] base, input logic [31:0] ns, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(build_hdr(base, ns + 32'(k)));
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: done not seen within %0d cycles, required done=1", name, budget);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({in_ready, hdr_valid, busy, done, frame_err} !== 5'b0 || header !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/vld/busy/done/err=%b header_nz=%0b, required 00000 and 0",
               {in_ready, hdr_valid, busy, done, frame_err}, header != '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || hdr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b busy=%0b hdr_valid=%0b, required 1 0 0", in_ready, busy, hdr_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int d0;
    d0 = done_cnt;
    hdr_ready = 1'b1;
    push_sweep(32'h1, 32'd5, 3);
    load_frame(32'h1, 18, 32'd5, 32'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (hdr_valid !== 1'b1 || busy !== 1'b1 || header[31:0] !== 32'(5 + k) || header[639:608] !== 32'h1) begin
        errors++;
        $display("FAIL basic_cycle%0d: vld=%0b busy=%0b nonce=%h word0=%h, required 1 1 %h 00000001",
                 k, hdr_valid, busy, header[31:0], header[639:608], 32'(5 + k));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || hdr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%0b vld=%0b busy=%0b, required 1 0 0", done, hdr_valid, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_reload: in_ready=%0b done=%0b, required 1 0", in_ready, done);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_totals: left=%0d dones=%0d, required 0 1", exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_stall;
    int pat[5] = '{0, 1, 0, 0, 1};
    int d0, h0;
    d0 = done_cnt;
    h0 = hs_cnt;
    hdr_ready = 1'b0;
    push_sweep(32'h1, 32'd0, 2);
    load_frame(32'h1, 18, 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      hdr_ready = pat[k][0];
      @(negedge clk);
      @(posedge clk); #1;
    end
    hdr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: done=%0b, required 1", done);
    end
    @(posedge clk); #1;
    checks++;
    if (hs_cnt - h0 != 2 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_totals: hs=%0d dones=%0d left=%0d, required 2 1 0", hs_cnt - h0, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_wrap;
    int h0;
    h0 = hs_cnt;
    hdr_ready = 1'b1;
    push_sweep(32'h20, 32'hFFFF_FFFE, 4);
    load_frame(32'h20, 18, 32'hFFFF_FFFE, 32'h1);
    wait_done(10, "wrap");
    checks++;
    if (hs_cnt - h0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_totals: hs=%0d left=%0d, required 4 0", hs_cnt - h0, exp_q.size());
    end
  endtask

  task automatic test_frame_err;
    int h0;
    h0 = hs_cnt;
    hdr_ready = 1'b1;
    load_frame(32'h40, 5, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_pulse: frame_err=%0b in_ready=%0b busy=%0b, required 1 1 0", frame_err, in_ready, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0 || hdr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ferr_single: frame_err=%0b hdr_valid=%0b, required 0 0", frame_err, hdr_valid);
    end
    @(posedge clk); #1;
    push_sweep(32'h300, 32'd3, 1);
    load_frame(32'h300, 18, 32'd3, 32'd3);
    wait_done(5, "ferr_reload");
    checks++;
    if (hs_cnt - h0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ferr_totals: hs=%0d left=%0d, required 1 0", hs_cnt - h0, exp_q.size());
    end
  endtask

  task automatic test_abort;
    int d0, h0;
    d0 = done_cnt;
    h0 = hs_cnt;
    hdr_ready = 1'b1;
    push_sweep(32'h500, 32'd0, 3);
    load_frame(32'h500, 18, 32'd0, 32'd100);
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (hdr_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: vld=%0b rdy=%0b busy=%0b done=%0b, required 0 1 0 0", hdr_valid, in_ready, busy, done);
    end
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    checks++;
    if (hs_cnt - h0 != 3 || done_cnt - d0 != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_totals: hs=%0d dones=%0d left=%0d, required 3 0 0", hs_cnt - h0, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int d0, h0;
    d0 = done_cnt;
    h0 = hs_cnt;
    hdr_ready = 1'b1;
    push_sweep(32'h600, 32'd0, 2);
    load_frame(32'h600, 18, 32'd0, 32'd9);
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, hdr_valid, busy, done, frame_err} !== 5'b0 || header !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: rdy/vld/busy/done/err=%b header_nz=%0b, required 00000 and 0",
               {in_ready, hdr_valid, busy, done, frame_err}, header != '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || hdr_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: rdy=%0b busy=%0b vld=%0b done=%0b, required 1 0 0 0", in_ready, busy, hdr_valid, done);
    end
    @(posedge clk); #1;
    checks++;
    if (hs_cnt - h0 != 2 || done_cnt - d0 != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_totals: hs=%0d dones=%0d left=%0d, required 2 0 0", hs_cnt - h0, done_cnt - d0, exp_q.size());
    end
    test_basic();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_frame_err();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
